// File: rtl/ad9226_axis_packer.sv
// ad9226_axis_packer: packs AD9226 ADC samples into a 16-bit AXI-Stream with a FIFO and fixed-length packets
// Optional feature macro: AD9226_AVG_EN (pairwise averaging, decimation by 2)
// Ports: clk, rst_n (async active-low), eoc/data_in/enable (ADC capture side),
//        m_axis_tdata/tvalid/tready/tlast (AXI-Stream master), overflow_count (dropped samples),
//        fifo_level (FIFO occupancy)
module ad9226_axis_packer #(
   parameter int ADC_DATA_WIDTH = 12,
   parameter int FIFO_DEPTH     = 16,
   parameter int PACKET_LEN     = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          eoc,
   input  logic [ADC_DATA_WIDTH-1:0]     data_in,
   input  logic                          enable,
   output logic [15:0]                   m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [15:0]                   overflow_count,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] LAST_BEAT = 16'(PACKET_LEN - 1);
   typedef enum logic {EMPTY, VALID} out_state_t;
   out_state_t state, state_nx;
   logic eoc_q, sample_evt, word_vld, full, pop, push, drop;
   logic [15:0] word;
   logic [15:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] level;
   logic [15:0] beat;

   assign sample_evt = eoc && !eoc_q && enable;

`ifdef AD9226_AVG_EN
   typedef enum logic {FIRST, SECOND} avg_state_t;
   avg_state_t avg_state, avg_nx;
   logic [ADC_DATA_WIDTH-1:0] held;
   logic signed [ADC_DATA_WIDTH:0] sum, avg;
   assign sum = $signed({held[ADC_DATA_WIDTH-1], held}) + $signed({data_in[ADC_DATA_WIDTH-1], data_in});
   assign avg = sum >>> 1;
   assign word_vld = sample_evt && avg_state == SECOND;
   assign word = {{(15 - ADC_DATA_WIDTH){avg[ADC_DATA_WIDTH]}}, avg};
   always_comb begin
      avg_nx = avg_state;
      if (!enable) avg_nx = FIRST;
      else if (sample_evt) avg_nx = avg_state == FIRST ? SECOND : FIRST;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         avg_state <= FIRST;
         held      <= '0;
      end else begin
         avg_state <= avg_nx;
         if (sample_evt && avg_state == FIRST) held <= data_in;
      end
   end
`else
   assign word_vld = sample_evt;
   assign word = {{(16 - ADC_DATA_WIDTH){data_in[ADC_DATA_WIDTH-1]}}, data_in};
`endif

   assign full = level == (AW + 1)'(FIFO_DEPTH);
   assign pop  = state == VALID && m_axis_tready;
   // A full FIFO still accepts a word when the head leaves in the same cycle.
   assign push = word_vld && (!full || pop);
   assign drop = word_vld && full && !pop;

   // Leaving VALID only when the popped word was the last one; a word written
   // on that same edge then takes the normal one-edge path through EMPTY.
   always_comb begin
      state_nx = state;
      if (state == EMPTY) state_nx = level != '0 ? VALID : EMPTY;
      else if (pop) state_nx = level > (AW + 1)'(1) ? VALID : EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eoc_q          <= 1'b0;
         state          <= EMPTY;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         level          <= '0;
         beat           <= '0;
         overflow_count <= '0;
      end else begin
         eoc_q <= eoc;
         state <= state_nx;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         level <= level + (AW + 1)'(push) - (AW + 1)'(pop);
         if (pop) beat <= beat == LAST_BEAT ? '0 : beat + 1'b1;
         if (drop && overflow_count != 16'hFFFF) overflow_count <= overflow_count + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= word;
   end

   assign m_axis_tvalid = state == VALID;
   assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;
   assign m_axis_tlast  = m_axis_tvalid && beat == LAST_BEAT;
   assign fifo_level    = level;
endmodule

// File: tb/tb_ad9226_axis_packer.sv
// tb_ad9226_axis_packer: directed self-checking bench for ad9226_axis_packer (PACKET_LEN=4, FIFO_DEPTH=16)
module tb_ad9226_axis_packer;
   logic clk = 1'b0, rst_n = 1'b0, eoc = 1'b0, enable = 1'b1, tready = 1'b0;
   logic [11:0] data_in = '0;
   logic [15:0] tdata, ovf;
   logic tvalid, tlast;
   logic [4:0] level;
   int checks = 0, errors = 0;

   ad9226_axis_packer #(.ADC_DATA_WIDTH(12), .FIFO_DEPTH(16), .PACKET_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n), .eoc(eoc), .data_in(data_in), .enable(enable),
      .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
      .m_axis_tlast(tlast), .overflow_count(ovf), .fifo_level(level)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0; eoc = 1'b0; enable = 1'b1; tready = 1'b0; data_in = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Returns at the negedge right after the event edge.
   task automatic pulse(input logic [11:0] d);
      @(negedge clk);
      eoc = 1'b1; data_in = d;
      @(negedge clk);
      eoc = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks += 5;
      if (tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
      if (tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast got %b want 0", tlast); end
      if (tdata !== 16'h0) begin errors++; $display("FAIL reset_tdata got %h want 0000", tdata); end
      if (ovf !== 16'h0) begin errors++; $display("FAIL reset_ovf got %h want 0000", ovf); end
      if (level !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level); end
      do_reset();
   endtask

`ifndef AD9226_AVG_EN
   task automatic test_latency();
      logic [11:0] vals [2];
      logic [15:0] exp [2];
      vals[0] = 12'h7FF; vals[1] = 12'h800;
      exp[0] = 16'h07FF; exp[1] = 16'hF800;
      do_reset();
      tready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         pulse(vals[k]);
         checks += 2;
         if (tvalid !== 1'b0) begin errors++; $display("FAIL lat_early_tvalid[%0d] got %b want 0", k, tvalid); end
         if (level !== 5'd1) begin errors++; $display("FAIL lat_level[%0d] got %0d want 1", k, level); end
         @(negedge clk);
         checks += 2;
         if (tvalid !== 1'b1) begin errors++; $display("FAIL lat_tvalid[%0d] got %b want 1", k, tvalid); end
         if (tdata !== exp[k]) begin errors++; $display("FAIL lat_tdata[%0d] got %h want %h", k, tdata, exp[k]); end
         @(negedge clk);
         checks++;
         if (tvalid !== 1'b0) begin errors++; $display("FAIL lat_drain[%0d] got %b want 0", k, tvalid); end
      end
   endtask

   task automatic test_eoc_held();
      do_reset();
      @(negedge clk);
      eoc = 1'b1; data_in = 12'd9;
      repeat (5) @(negedge clk);
      eoc = 1'b0;
      @(negedge clk);
      checks++;
      if (level !== 5'd1) begin errors++; $display("FAIL eoc_held_level got %0d want 1", level); end
   endtask

   task automatic test_packet();
      do_reset();
      for (int i = 0; i < 9; i++) pulse(12'(i * 3 + 5));
      @(negedge clk);
      tready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         checks += 3;
         if (tvalid !== 1'b1) begin errors++; $display("FAIL pkt_tvalid[%0d] got %b want 1", i, tvalid); end
         if (tdata !== 16'(i * 3 + 5)) begin errors++; $display("FAIL pkt_tdata[%0d] got %h want %h", i, tdata, 16'(i * 3 + 5)); end
         if (tlast !== (i == 3 || i == 7)) begin errors++; $display("FAIL pkt_tlast[%0d] got %b want %b", i, tlast, (i == 3 || i == 7)); end
         @(negedge clk);
      end
      checks++;
      if (tvalid !== 1'b0) begin errors++; $display("FAIL pkt_end_tvalid got %b want 0", tvalid); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 19; i++) pulse(12'(i + 1));
      @(negedge clk);
      checks += 3;
      if (level !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", level); end
      if (ovf !== 16'd3) begin errors++; $display("FAIL ovf_count got %0d want 3", ovf); end
      if (tdata !== 16'd1) begin errors++; $display("FAIL ovf_hold_tdata got %h want 0001", tdata); end
      tready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks += 3;
         if (tvalid !== 1'b1) begin errors++; $display("FAIL ovf_tvalid[%0d] got %b want 1", i, tvalid); end
         if (tdata !== 16'(i + 1)) begin errors++; $display("FAIL ovf_tdata[%0d] got %h want %h", i, tdata, 16'(i + 1)); end
         if (tlast !== (i % 4 == 3)) begin errors++; $display("FAIL ovf_tlast[%0d] got %b want %b", i, tlast, (i % 4 == 3)); end
         @(negedge clk);
      end
      checks++;
      if (tvalid !== 1'b0) begin errors++; $display("FAIL ovf_extra_beat got %b want 0", tvalid); end
   endtask

   task automatic test_full_handshake();
      do_reset();
      for (int i = 0; i < 16; i++) pulse(12'(i + 1));
      @(negedge clk);
      eoc = 1'b1; data_in = 12'h123; tready = 1'b1;
      @(negedge clk);
      eoc = 1'b0; tready = 1'b0;
      checks += 2;
      if (level !== 5'd16) begin errors++; $display("FAIL full_hs_level got %0d want 16", level); end
      if (ovf !== 16'd0) begin errors++; $display("FAIL full_hs_ovf got %0d want 0", ovf); end
      tready = 1'b1;
      for (int i = 0; i < 15; i++) @(negedge clk);
      checks += 2;
      if (tvalid !== 1'b1) begin errors++; $display("FAIL full_hs_tvalid got %b want 1", tvalid); end
      if (tdata !== 16'h0123) begin errors++; $display("FAIL full_hs_tdata got %h want 0123", tdata); end
   endtask

   task automatic test_enable();
      do_reset();
      enable = 1'b0;
      pulse(12'd5);
      @(negedge clk);
      checks++;
      if (level !== 5'd0) begin errors++; $display("FAIL en_off_level got %0d want 0", level); end
      enable = 1'b1;
      pulse(12'd6);
      enable = 1'b0;
      pulse(12'd7);
      @(negedge clk);
      checks += 2;
      if (level !== 5'd1) begin errors++; $display("FAIL en_level got %0d want 1", level); end
      if (tdata !== 16'd6) begin errors++; $display("FAIL en_drain_tdata got %h want 0006", tdata); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      pulse(12'd1);
      pulse(12'd2);
      @(negedge clk);
      tready = 1'b1;
      @(negedge clk);
      tready = 1'b0;
      checks++;
      if (tvalid !== 1'b1) begin errors++; $display("FAIL mid_pre_tvalid got %b want 1", tvalid); end
      #2 rst_n = 1'b0;
      #1;
      checks += 2;
      if (tvalid !== 1'b0) begin errors++; $display("FAIL mid_async_tvalid got %b want 0", tvalid); end
      if (level !== 5'd0) begin errors++; $display("FAIL mid_async_level got %0d want 0", level); end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) pulse(12'(i + 20));
      @(negedge clk);
      tready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks += 2;
         if (tdata !== 16'(i + 20)) begin errors++; $display("FAIL mid_tdata[%0d] got %h want %h", i, tdata, 16'(i + 20)); end
         if (tlast !== (i == 3)) begin errors++; $display("FAIL mid_tlast[%0d] got %b want %b", i, tlast, (i == 3)); end
         @(negedge clk);
      end
   endtask
`else
   task automatic test_average();
      logic [15:0] exp [3];
      exp[0] = 16'hFFFE; exp[1] = 16'd100; exp[2] = 16'd15;
      do_reset();
      pulse(12'hFFD);
      pulse(12'd0);
      pulse(12'd100);
      pulse(12'd101);
      pulse(12'd7);
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (level !== 5'd2) begin errors++; $display("FAIL avg_odd_level got %0d want 2", level); end
      enable = 1'b1;
      pulse(12'd10);
      pulse(12'd20);
      @(negedge clk);
      checks++;
      if (level !== 5'd3) begin errors++; $display("FAIL avg_level got %0d want 3", level); end
      tready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks += 2;
         if (tvalid !== 1'b1) begin errors++; $display("FAIL avg_tvalid[%0d] got %b want 1", i, tvalid); end
         if (tdata !== exp[i]) begin errors++; $display("FAIL avg_tdata[%0d] got %h want %h", i, tdata, exp[i]); end
         @(negedge clk);
      end
      checks++;
      if (tvalid !== 1'b0) begin errors++; $display("FAIL avg_extra_beat got %b want 0", tvalid); end
   endtask
`endif

   initial begin
      test_reset();
`ifndef AD9226_AVG_EN
      test_latency();
      test_eoc_held();
      test_packet();
      test_overflow();
      test_full_handshake();
      test_enable();
      test_reset_mid();
`else
      test_average();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
